// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types, constants and bus-drive decode for the I2C register-write master
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } i2c_state_t;

    typedef logic [1:0] quarter_t;

    localparam int I2C_NUM_BYTES       = 3;
    localparam int I2C_CLK_DIV_DEFAULT = 62;
    localparam int I2C_DIV_W           = 10;

    // Returns {scl_low, sda_low} for a state/quarter; bit_val is the data bit currently on the wire.
    function automatic logic [1:0] bus_drive(input i2c_state_t st, input quarter_t q, input logic bit_val);
        logic scl_low;
        logic sda_low;
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (st)
            ST_START: begin
                scl_low = (q == 2'd3);
                sda_low = (q != 2'd0);
            end
            ST_BIT: begin
                scl_low = (q == 2'd0) || (q == 2'd3);
                sda_low = ~bit_val;
            end
            ST_ACK: begin
                scl_low = (q == 2'd0) || (q == 2'd3);
                sda_low = 1'b0;
            end
            ST_STOP: begin
                scl_low = (q == 2'd0);
                sda_low = (q == 2'd0) || (q == 2'd1);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
        return {scl_low, sda_low};
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter-period tick generator with 2-bit quarter index and synchronous clear
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_clear,
    output logic     o_tick,
    output quarter_t o_quarter,
    output quarter_t o_quarter_nxt
);

    localparam logic [I2C_DIV_W-1:0] TICK_MAX = I2C_DIV_W'(CLK_DIV - 1);
    localparam logic [I2C_DIV_W-1:0] CNT_ONE  = I2C_DIV_W'(1);

    logic [I2C_DIV_W-1:0] r_cnt;
    quarter_t             r_quarter;

    assign o_tick    = (r_cnt == TICK_MAX);
    assign o_quarter = r_quarter;

    // Exposed so the controller can register its bus outputs aligned with the quarter they belong to.
    always_comb begin
        o_quarter_nxt = r_quarter;
        if (i_clear) begin
            o_quarter_nxt = '0;
        end else if (o_tick) begin
            o_quarter_nxt = r_quarter + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
        if (reset) begin
            r_quarter <= '0;
        end else begin
            r_quarter <= o_quarter_nxt;
        end
    end

endmodule

// File: rtl/i2c_reg_write_ctrl.sv
// rtl/i2c_reg_write_ctrl.sv - I2C master sequencing START, dev+W, reg, data, STOP single-register writes
// Optional feature macro: I2C_ACK_CHECK_EN (NACK aborts to STOP and raises ack_err).
module i2c_reg_write_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    i2c_state_t r_state;
    i2c_state_t w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [1:0] r_byte_idx;
    logic [1:0] w_byte_idx_nxt;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       r_ack_bit;
    logic       w_ack_bit_nxt;
    logic       r_ack_err;
    logic       w_ack_err_nxt;
    logic       r_busy;
    logic       r_done;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       w_accept;
    logic       w_tick;
    logic       w_q_end;
    logic       w_abort;
    logic       w_scl_nxt;
    logic       w_sda_nxt;
    quarter_t   w_quarter;
    quarter_t   w_quarter_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;

    i2c_qtick #(
        .CLK_DIV(CLK_DIV)
    ) u_qtick (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_accept),
        .o_tick       (w_tick),
        .o_quarter    (w_quarter),
        .o_quarter_nxt(w_quarter_nxt)
    );

    assign w_q_end = w_tick && (w_quarter == 2'd3);

`ifdef I2C_ACK_CHECK_EN
    assign w_abort = r_ack_bit;
`else
    logic w_ack_unused;
    assign w_abort      = 1'b0;
    assign w_ack_unused = r_ack_bit;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_idx_nxt = r_byte_idx;
        w_ack_bit_nxt  = r_ack_bit;
        w_ack_err_nxt  = r_ack_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_START;
                    w_shift_nxt    = {dev_addr, 1'b0};
                    w_bit_cnt_nxt  = '0;
                    w_byte_idx_nxt = '0;
                    w_ack_bit_nxt  = 1'b0;
                    w_ack_err_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_q_end) begin
                    w_state_nxt = ST_BIT;
                end
            end
            ST_BIT: begin
                if (w_q_end) begin
                    w_shift_nxt   = {r_shift[6:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (w_tick && (w_quarter == 2'd2)) begin
                    w_ack_bit_nxt = sda_i;
                end
                if (w_q_end) begin
                    if (w_abort || (r_byte_idx == 2'(I2C_NUM_BYTES - 1))) begin
                        w_state_nxt   = ST_STOP;
                        w_ack_err_nxt = w_abort;
                    end else begin
                        w_state_nxt    = ST_BIT;
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_shift_nxt    = (r_byte_idx == 2'd0) ? r_reg_addr : r_reg_data;
                    end
                end
            end
            ST_STOP: begin
                if (w_q_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus enables are decoded from next-state values so the registered outputs line up with the state.
    assign {w_scl_nxt, w_sda_nxt} = bus_drive(w_state_nxt, w_quarter_nxt, w_shift_nxt[7]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_ack_bit  <= 1'b0;
            r_ack_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_ack_bit  <= w_ack_bit_nxt;
            r_ack_err  <= w_ack_err_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_scl_oe   <= w_scl_nxt;
            r_sda_oe   <= w_sda_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_addr <= '0;
            r_reg_data <= '0;
        end else if (w_accept) begin
            r_reg_addr <= reg_addr;
            r_reg_data <= reg_data;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign scl_oe  = r_scl_oe;
    assign sda_oe  = r_sda_oe;

endmodule

// File: tb/tb_i2c_reg_write_ctrl.sv
// tb/tb_i2c_reg_write_ctrl.sv - scoreboard bench: bus-level I2C decoder and slave versus a transaction model
module tb_i2c_reg_write_ctrl;

    localparam int D        = 4;
    localparam int LIMIT    = 2000;
    localparam int EV_START = 0;
    localparam int EV_BYTE  = 1;
    localparam int EV_STOP  = 2;
    localparam int EV_DONE  = 3;

`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       slave_pull = 1'b0;
    logic       sda_line;

    assign sda_line = ~sda_oe & ~slave_pull;

    i2c_reg_write_ctrl #(
        .CLK_DIV(D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dev_addr(dev_addr),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .sda_i   (sda_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int aux;
    } ev_t;

    ev_t exp_q[$];
    int  nack_q[$];
    int  checks      = 0;
    int  failures    = 0;
    int  last_ack_exp = 0;
    int  cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            EV_START: return "start";
            EV_BYTE:  return "byte";
            EV_STOP:  return "stop";
            default:  return "done";
        endcase
    endfunction

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic sb_check(input int kind, input int val, input int aux);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_%s actual val=%0h aux=%0d required none", kind_name(kind), val, aux);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == EV_DONE) last_ack_exp = e.aux;
        if (e.kind != kind || e.val != val || e.aux != aux) begin
            failures++;
            $display("FAIL sb_%s actual %s val=%0h aux=%0d required %s val=%0h aux=%0d",
                     kind_name(e.kind), kind_name(kind), val, aux, kind_name(e.kind), e.val, e.aux);
        end
    endtask

    // Transaction-level model: which events the bus and handshake should show for one write.
    task automatic push_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v, input int nack_at);
        logic [7:0] bytes [3];
        bit abort;
        int nbytes;
        bytes[0] = {d, 1'b0};
        bytes[1] = r;
        bytes[2] = v;
        abort    = ACK_CHECK && (nack_at >= 0);
        nbytes   = abort ? nack_at + 1 : 3;
        exp_q.push_back(ev_t'{EV_START, 1, 0});
        for (int i = 0; i < nbytes; i++) exp_q.push_back(ev_t'{EV_BYTE, int'(bytes[i]), 0});
        exp_q.push_back(ev_t'{EV_STOP, 0, 0});
        exp_q.push_back(ev_t'{EV_DONE, (4 + 36 * nbytes + 4) * D + 1, int'(abort)});
        nack_q.push_back(nack_at);
    endtask

    function automatic logic sig_of(input int which);
        return (which == 0) ? busy : done;
    endfunction

    task automatic wait_sig(input int which, input logic level, input string name);
        int n = 0;
        while (sig_of(which) !== level && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=expired required=level %0d", name, level);
        end
    endtask

    task automatic run_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                           input int nack_at, input bit mid_pulse);
        push_txn(d, r, v, nack_at);
        dev_addr = d;
        reg_addr = r;
        reg_data = v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sig(0, 1'b1, "accept");
        dev_addr = 7'($urandom);
        reg_addr = 8'($urandom);
        reg_data = 8'($urandom);
        if (mid_pulse) begin
            repeat ($urandom_range(10, 150)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_sig(1, 1'b1, "done");
        wait_sig(0, 1'b0, "idle");
    endtask

    // Bus decoder plus ACKing slave; every observed event is handed to the scoreboard.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_busy = 1'b0;
    logic       prev_ack_err = 1'b0;
    logic [7:0] shreg = '0;
    bit         in_xfer = 1'b0;
    int         idle_run = 0;
    int         bitcnt = 0;
    int         byte_no = 0;
    int         cur_nack = -1;
    int         acc_cyc = 0;

    always @(negedge clk) begin
        logic scl;
        logic sda;
        scl = ~scl_oe;
        sda = sda_line;
        if (reset) begin
            in_xfer    = 1'b0;
            bitcnt     = 0;
            slave_pull = 1'b0;
            idle_run   = 0;
        end else begin
            if (busy && !prev_busy) begin
                acc_cyc = cyc;
                expect_eq("ack_err_cleared_on_accept", ack_err, 0);
                expect_eq("ack_err_held_until_accept", prev_ack_err, last_ack_exp);
            end
            if (prev_scl && scl && prev_sda && !sda) begin
                sb_check(EV_START, int'(idle_run >= D), 0);
                in_xfer = 1'b1;
                bitcnt  = 0;
                byte_no = 0;
                shreg   = '0;
                cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : -1;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                sb_check(EV_STOP, 0, 0);
                in_xfer = 1'b0;
            end else begin
                if (!prev_scl && scl && in_xfer) begin
                    bitcnt++;
                    if (bitcnt <= 8) begin
                        shreg = {shreg[6:0], sda};
                    end else begin
                        sb_check(EV_BYTE, int'(shreg), 0);
                        byte_no++;
                    end
                end
                if (prev_scl && !scl && in_xfer) begin
                    if (bitcnt == 8) begin
                        slave_pull = (cur_nack != byte_no);
                    end else if (bitcnt == 9) begin
                        slave_pull = 1'b0;
                        bitcnt     = 0;
                    end
                end
            end
            if (done) sb_check(EV_DONE, cyc - acc_cyc + 1, int'(ack_err));
            idle_run = (scl && sda) ? idle_run + 1 : 0;
        end
        prev_scl     = scl;
        prev_sda     = sda;
        prev_busy    = busy;
        prev_ack_err = ack_err;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d;
        logic [7:0] r;
        logic [7:0] v;
        reset    = 1'b1;
        start    = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        reg_data = '0;
        repeat (3) @(negedge clk);
        expect_eq("reset_busy", busy, 0);
        expect_eq("reset_done", done, 0);
        expect_eq("reset_ack_err", ack_err, 0);
        expect_eq("reset_scl_oe", scl_oe, 0);
        expect_eq("reset_sda_oe", sda_oe, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(7'h39, 8'h41, 8'h10, -1, 1'b0);
        run_txn(7'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0);
        run_txn(7'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0);
        run_txn(7'h5A, 8'hC3, 8'h81, -1, 1'b1);

        // Reset in the middle of the reg_addr byte, bit 3.
        d = 7'($urandom);
        r = 8'($urandom);
        v = 8'($urandom);
        push_txn(d, r, v, -1);
        dev_addr = d;
        reg_addr = r;
        reg_data = v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sig(0, 1'b1, "accept_rst");
        repeat ((4 + 36 + 12 + 1) * D) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        nack_q.delete();
        last_ack_exp = 0;
        @(negedge clk);
        expect_eq("rst_mid_scl_oe", scl_oe, 0);
        expect_eq("rst_mid_sda_oe", sda_oe, 0);
        expect_eq("rst_mid_busy", busy, 0);
        expect_eq("rst_mid_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn(7'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);

        // Back-to-back with start held high across the first transaction.
        push_txn(7'h11, 8'h22, 8'h33, -1);
        dev_addr = 7'h11;
        reg_addr = 8'h22;
        reg_data = 8'h33;
        start    = 1'b1;
        @(negedge clk);
        wait_sig(0, 1'b1, "b2b_accept1");
        d = 7'($urandom);
        r = 8'($urandom);
        v = 8'($urandom);
        push_txn(d, r, v, -1);
        dev_addr = d;
        reg_addr = r;
        reg_data = v;
        wait_sig(1, 1'b1, "b2b_done1");
        @(negedge clk);
        expect_eq("b2b_gap_busy_low", busy, 0);
        @(negedge clk);
        expect_eq("b2b_reaccept_busy", busy, 1);
        start = 1'b0;
        wait_sig(1, 1'b1, "b2b_done2");
        wait_sig(0, 1'b0, "b2b_idle");

        for (int i = 0; i < 6; i++) begin
            run_txn(7'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)) - 1, 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        expect_eq("sb_drained", exp_q.size(), 0);
        expect_eq("nack_plan_drained", nack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
